// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the pipelined 74181-style ALU.
//   MODE_ARITH / MODE_LOGIC : values of the mode bit
//   S_*                      : function-select codes (arithmetic and logic
//                              tables reuse the same 4-bit space)
//   op_ctl_t                 : control fields captured with each operation
package alu_pkg;

  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;

  // Arithmetic functions (M=0); result = F + cin
  localparam logic [3:0] S_TFR       = 4'b0000; // A
  localparam logic [3:0] S_TFR_OR    = 4'b0001; // A|B
  localparam logic [3:0] S_TFR_ORN   = 4'b0010; // A|~B
  localparam logic [3:0] S_MINUS1    = 4'b0011; // -1
  localparam logic [3:0] S_A_PL_ANB  = 4'b0100; // A+(A&~B)
  localparam logic [3:0] S_OR_PL_ANB = 4'b0101; // (A|B)+(A&~B)
  localparam logic [3:0] S_SUBM1     = 4'b0110; // A-B-1
  localparam logic [3:0] S_ANB_M1    = 4'b0111; // (A&~B)-1
  localparam logic [3:0] S_A_PL_AB   = 4'b1000; // A+(A&B)
  localparam logic [3:0] S_ADD       = 4'b1001; // A+B
  localparam logic [3:0] S_ORN_PL_AB = 4'b1010; // (A|~B)+(A&B)
  localparam logic [3:0] S_AB_M1     = 4'b1011; // (A&B)-1
  localparam logic [3:0] S_DBL       = 4'b1100; // A+A
  localparam logic [3:0] S_OR_PL_A   = 4'b1101; // (A|B)+A
  localparam logic [3:0] S_ORN_PL_A  = 4'b1110; // (A|~B)+A
  localparam logic [3:0] S_DEC       = 4'b1111; // A-1

  // Logic functions (M=1)
  localparam logic [3:0] S_NOT_A     = 4'b0000;
  localparam logic [3:0] S_NOR       = 4'b0001;
  localparam logic [3:0] S_NA_AND_B  = 4'b0010;
  localparam logic [3:0] S_ZERO      = 4'b0011;
  localparam logic [3:0] S_NAND      = 4'b0100;
  localparam logic [3:0] S_NOT_B     = 4'b0101;
  localparam logic [3:0] S_XOR       = 4'b0110;
  localparam logic [3:0] S_A_AND_NB  = 4'b0111;
  localparam logic [3:0] S_NA_OR_B   = 4'b1000;
  localparam logic [3:0] S_XNOR      = 4'b1001;
  localparam logic [3:0] S_PASS_B    = 4'b1010;
  localparam logic [3:0] S_AND       = 4'b1011;
  localparam logic [3:0] S_ONES      = 4'b1100;
  localparam logic [3:0] S_A_OR_NB   = 4'b1101;
  localparam logic [3:0] S_OR        = 4'b1110;
  localparam logic [3:0] S_PASS_A    = 4'b1111;

  typedef struct packed {
    logic       mode;
    logic [3:0] select;
    logic       carry_in;
    logic       chain;
  } op_ctl_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational 74181-style function unit.
//   mode, sel, cin, a, b -> result, carry (bit WIDTH of the sum), ovf
//   Arithmetic: result = x + y + cin at WIDTH+1 bits, each term zero-extended.
//   Logic: bitwise table; carry and ovf forced to 0.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             mode,
  input  logic [3:0]       sel,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf
);

  logic [WIDTH-1:0] nb, ones, x, y, lres;
  logic [WIDTH:0]   sum;
  logic             c_msb;

  assign nb   = ~b;
  assign ones = '1;

  // Every arithmetic function is a sum of at most two terms; "X-1" is X + all-ones.
  always_comb begin
    x = a;
    y = '0;
    case (sel)
      S_TFR:       begin x = a;      y = '0;     end
      S_TFR_OR:    begin x = a | b;  y = '0;     end
      S_TFR_ORN:   begin x = a | nb; y = '0;     end
      S_MINUS1:    begin x = ones;   y = '0;     end
      S_A_PL_ANB:  begin x = a;      y = a & nb; end
      S_OR_PL_ANB: begin x = a | b;  y = a & nb; end
      S_SUBM1:     begin x = a;      y = nb;     end
      S_ANB_M1:    begin x = a & nb; y = ones;   end
      S_A_PL_AB:   begin x = a;      y = a & b;  end
      S_ADD:       begin x = a;      y = b;      end
      S_ORN_PL_AB: begin x = a | nb; y = a & b;  end
      S_AB_M1:     begin x = a & b;  y = ones;   end
      S_DBL:       begin x = a;      y = a;      end
      S_OR_PL_A:   begin x = a | b;  y = a;      end
      S_ORN_PL_A:  begin x = a | nb; y = a;      end
      S_DEC:       begin x = a;      y = ones;   end
      default:     begin x = a;      y = '0;     end
    endcase
  end

  always_comb begin
    lres = '0;
    case (sel)
      S_NOT_A:    lres = ~a;
      S_NOR:      lres = ~(a | b);
      S_NA_AND_B: lres = ~a & b;
      S_ZERO:     lres = '0;
      S_NAND:     lres = ~(a & b);
      S_NOT_B:    lres = nb;
      S_XOR:      lres = a ^ b;
      S_A_AND_NB: lres = a & nb;
      S_NA_OR_B:  lres = ~a | b;
      S_XNOR:     lres = ~(a ^ b);
      S_PASS_B:   lres = b;
      S_AND:      lres = a & b;
      S_ONES:     lres = ones;
      S_A_OR_NB:  lres = a | nb;
      S_OR:       lres = a | b;
      S_PASS_A:   lres = a;
      default:    lres = '0;
    endcase
  end

  assign sum   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
  // Carry into the MSB recovered from the MSB sum bit and its two addend bits.
  assign c_msb = sum[WIDTH-1] ^ x[WIDTH-1] ^ y[WIDTH-1];

  assign result = (mode == MODE_LOGIC) ? lres : sum[WIDTH-1:0];
  assign carry  = (mode == MODE_LOGIC) ? 1'b0 : sum[WIDTH];
  assign ovf    = (mode == MODE_LOGIC) ? 1'b0 : (c_msb ^ sum[WIDTH]);

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready pipelined ALU with sticky chain carry.
//   clk, rst_n        : clock, async active-low reset
//   i_flush           : drop both stages and clear the chain carry
//   i_valid/i_ready   : operation handshake; i_mode, i_select, i_carry_in,
//                       i_chain, i_a, i_b, i_tag describe the operation
//   o_valid/o_ready   : result handshake; o_result, o_carry, o_compare,
//                       o_zero, o_neg, o_ovf, o_tag describe the result
// S1 holds the captured operation; the function is evaluated as S1 moves into
// S2 (the output register), so the chain carry is always that of the most
// recent arithmetic op already in S2 -- no bypass is needed back-to-back.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic             i_mode,
  input  logic [3:0]       i_select,
  input  logic             i_carry_in,
  input  logic             i_chain,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_compare,
  output logic             o_zero,
  output logic             o_neg,
  output logic             o_ovf,
  output logic [TAG_W-1:0] o_tag
);

  localparam int STAGES = 2;

  logic [STAGES:1]  vld_pipe;  // [1] = S1 occupied, [2] = S2 occupied
  logic             adv1, adv2, accept;
  op_ctl_t          s1_ctl;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [TAG_W-1:0] s1_tag;
  logic             carry_reg, cin;
  logic [WIDTH-1:0] c_result;
  logic             c_carry, c_ovf;

  assign adv2    = !vld_pipe[2] | o_ready;
  assign adv1    = !vld_pipe[1] | adv2;
  assign i_ready = adv1 & !i_flush & rst_n;
  assign accept  = i_valid & i_ready;
  assign o_valid = vld_pipe[2];
  assign cin     = s1_ctl.chain ? carry_reg : s1_ctl.carry_in;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .mode   (s1_ctl.mode),
    .sel    (s1_ctl.select),
    .cin    (cin),
    .a      (s1_a),
    .b      (s1_b),
    .result (c_result),
    .carry  (c_carry),
    .ovf    (c_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      s1_ctl    <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_tag    <= '0;
      carry_reg <= 1'b0;
      o_result  <= '0;
      o_carry   <= 1'b0;
      o_compare <= 1'b0;
      o_zero    <= 1'b0;
      o_neg     <= 1'b0;
      o_ovf     <= 1'b0;
      o_tag     <= '0;
    end else if (i_flush) begin
      vld_pipe  <= '0;
      carry_reg <= 1'b0;
    end else begin
      if (adv1) begin
        vld_pipe[1] <= accept;
        if (accept) begin
          s1_ctl <= '{mode: i_mode, select: i_select, carry_in: i_carry_in, chain: i_chain};
          s1_a   <= i_a;
          s1_b   <= i_b;
          s1_tag <= i_tag;
        end
      end
      if (adv2) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          o_result  <= c_result;
          o_carry   <= c_carry;
          o_ovf     <= c_ovf;
          o_compare <= (s1_a == s1_b);
          o_zero    <= (c_result == '0);
          o_neg     <= c_result[WIDTH-1];
          o_tag     <= s1_tag;
          if (s1_ctl.mode == MODE_ARITH) carry_reg <= c_carry;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

  localparam int W = 16;
  localparam int T = 4;

  logic          clk, rst_n, i_flush, i_valid, i_ready, i_mode, i_carry_in, i_chain;
  logic [3:0]    i_select;
  logic [W-1:0]  i_a, i_b;
  logic [T-1:0]  i_tag;
  logic          o_valid, o_ready, o_carry, o_compare, o_zero, o_neg, o_ovf;
  logic [W-1:0]  o_result;
  logic [T-1:0]  o_tag;

  alu_pipe #(.WIDTH(W), .TAG_W(T)) dut (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_valid(i_valid), .i_ready(i_ready),
    .i_mode(i_mode), .i_select(i_select), .i_carry_in(i_carry_in), .i_chain(i_chain),
    .i_a(i_a), .i_b(i_b), .i_tag(i_tag), .o_valid(o_valid), .o_ready(o_ready),
    .o_result(o_result), .o_carry(o_carry), .o_compare(o_compare), .o_zero(o_zero),
    .o_neg(o_neg), .o_ovf(o_ovf), .o_tag(o_tag)
  );

  typedef struct packed {
    logic [15:0] res;
    logic c, v, cmp, z, n;
    logic [3:0] tag;
  } exp_t;

  exp_t       q[$];
  int         checks = 0, errors = 0;
  logic       mcarry = 1'b0;
  logic [3:0] tag_ctr = 4'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] r, input logic c, v, cmp, z, n);
    exp_t e;
    e = '{res: r, c: c, v: v, cmp: cmp, z: z, n: n, tag: 4'h0};
    return e;
  endfunction

  // Reference: plain integer sums of the table's terms; overflow from the
  // carry produced by the low 15 bits against the carry out of bit 15.
  function automatic exp_t model(input logic mode, input logic [3:0] sel, input logic cin,
                                 input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic [15:0] nb, ab, anb, ob, onb, r;
    int unsigned x, y, s, lo;
    nb = ~b; ab = a & b; anb = a & nb; ob = a | b; onb = a | nb;
    e = '0;
    if (mode) begin
      case (sel)
        4'h0: r = ~a;        4'h1: r = ~ob;       4'h2: r = ~a & b;   4'h3: r = 16'h0000;
        4'h4: r = ~ab;       4'h5: r = nb;        4'h6: r = a ^ b;    4'h7: r = anb;
        4'h8: r = ~a | b;    4'h9: r = ~(a ^ b);  4'hA: r = b;        4'hB: r = ab;
        4'hC: r = 16'hFFFF;  4'hD: r = onb;       4'hE: r = ob;       default: r = a;
      endcase
    end else begin
      case (sel)
        4'h0: begin x = a;   y = 0;       end
        4'h1: begin x = ob;  y = 0;       end
        4'h2: begin x = onb; y = 0;       end
        4'h3: begin x = 32'hFFFF; y = 0;  end
        4'h4: begin x = a;   y = anb;     end
        4'h5: begin x = ob;  y = anb;     end
        4'h6: begin x = a;   y = nb;      end
        4'h7: begin x = anb; y = 32'hFFFF; end
        4'h8: begin x = a;   y = ab;      end
        4'h9: begin x = a;   y = b;       end
        4'hA: begin x = onb; y = ab;      end
        4'hB: begin x = ab;  y = 32'hFFFF; end
        4'hC: begin x = a;   y = a;       end
        4'hD: begin x = ob;  y = a;       end
        4'hE: begin x = onb; y = a;       end
        default: begin x = a; y = 32'hFFFF; end
      endcase
      s   = x + y + cin;
      lo  = (x % 32768) + (y % 32768) + cin;
      r   = s[15:0];
      e.c = (s >= 65536);
      e.v = (lo >= 32768) ^ e.c;
    end
    e.res = r;
    e.cmp = (a == b);
    e.z   = (r == 16'h0000);
    e.n   = r[15];
    return e;
  endfunction

  // One clock of stimulus; entered and left just after a rising edge.
  task automatic cycle(input logic v, input logic mode, input logic [3:0] sel, input logic cin,
                       input logic chain, input logic [15:0] a, input logic [15:0] b,
                       input logic ordy, input logic flush, input logic use_exp,
                       input exp_t dexp, output logic acc);
    exp_t e;
    i_valid = v; i_mode = mode; i_select = sel; i_carry_in = cin; i_chain = chain;
    i_a = a; i_b = b; i_tag = tag_ctr; o_ready = ordy; i_flush = flush;
    @(negedge clk);
    acc = i_valid && i_ready;
    @(posedge clk);
    #1;
    if (flush) begin
      q.delete();
      mcarry = 1'b0;
    end else if (acc) begin
      e = model(mode, sel, chain ? mcarry : cin, a, b);
      if (!mode) mcarry = e.c;
      if (use_exp) e = dexp;
      e.tag = tag_ctr;
      q.push_back(e);
      tag_ctr++;
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++) cycle(0, 0, 4'h0, 0, 0, 16'h0, 16'h0, ordy, 0, 0, '0, acc);
  endtask

  // Monitor: pops on every handshake and checks that a stalled result holds.
  logic        prev_hold = 1'b0;
  logic [24:0] snap;
  always @(negedge clk) begin
    exp_t e;
    if (prev_hold && rst_n)
      chk("hold_stable", {7'b0, o_valid, o_result, o_carry, o_ovf, o_compare, o_zero, o_neg, o_tag},
          {7'b0, 1'b1, snap});
    if (rst_n && o_valid && o_ready) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: actual tag=%0h required=no output", o_tag);
      end else begin
        e = q.pop_front();
        chk("result", {7'b0, o_result, o_carry, o_ovf, o_compare, o_zero, o_neg, o_tag}, {7'b0, e});
      end
    end
    prev_hold = rst_n && o_valid && !o_ready && !i_flush;
    snap = {o_result, o_carry, o_ovf, o_compare, o_zero, o_neg, o_tag};
  end

  initial begin
    logic acc;
    int   n, guard;
    logic [15:0] ra [4];
    logic [15:0] rb [4];
    rst_n = 0; i_flush = 0; i_valid = 0; i_mode = 0; i_select = 0; i_carry_in = 0;
    i_chain = 0; i_a = 0; i_b = 0; i_tag = 0; o_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_i_ready", i_ready, 0);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_outputs", {o_result, o_carry, o_compare, o_zero, o_neg, o_ovf, o_tag}, 0);
    #1 rst_n = 1;
    @(posedge clk); #1;
    chk("post_rst_i_ready", i_ready, 1);

    // ADD 7FFF+1, with latency check
    cycle(1, 0, 4'h9, 0, 0, 16'h7FFF, 16'h0001, 1, 0, 1, mk(16'h8000, 0, 1, 0, 0, 1), acc);
    chk("lat_cycle1", o_valid, 0);
    idle(1, 1);
    chk("lat_cycle2", o_valid, 1);
    idle(2, 1);

    // carry chain back-to-back
    cycle(1, 0, 4'h9, 0, 0, 16'hFFFF, 16'h0001, 1, 0, 1, mk(16'h0000, 1, 0, 0, 1, 0), acc);
    cycle(1, 0, 4'h9, 0, 1, 16'h0000, 16'h0000, 1, 0, 1, mk(16'h0001, 0, 0, 1, 0, 0), acc);
    idle(2, 1);

    // logic XOR and pass-A
    cycle(1, 1, 4'h6, 1, 0, 16'hF0F0, 16'hFF00, 1, 0, 1, mk(16'h0FF0, 0, 0, 0, 0, 0), acc);
    cycle(1, 1, 4'hF, 0, 0, 16'h1234, 16'h1234, 1, 0, 1, mk(16'h1234, 0, 0, 1, 0, 0), acc);
    idle(3, 1);

    // backpressure: 4 ops offered under 5 stalled cycles
    for (int i = 0; i < 4; i++) begin ra[i] = 16'($urandom); rb[i] = 16'($urandom); end
    n = 0;
    for (int c = 0; c < 5; c++) begin
      cycle(1, 0, 4'h9, 0, 0, ra[n], rb[n], 0, 0, 0, '0, acc);
      if (acc) n++;
    end
    chk("bp_accepted", n, 2);
    chk("bp_i_ready", i_ready, 0);
    guard = 0;
    while (n < 4 && guard < 20) begin
      cycle(1, 0, 4'h9, 0, 0, ra[n], rb[n], 1, 0, 0, '0, acc);
      if (acc) n++;
      guard++;
    end
    chk("bp_all_accepted", n, 4);
    idle(4, 1);

    // flush with both stages full and an op offered
    cycle(1, 0, 4'h9, 0, 0, 16'hFFFF, 16'h0001, 0, 0, 0, '0, acc);
    cycle(1, 0, 4'h9, 0, 0, 16'hFFFF, 16'h0001, 0, 0, 0, '0, acc);
    chk("flush_prefill", o_valid, 1);
    cycle(1, 0, 4'h9, 0, 0, 16'h1111, 16'h2222, 1, 1, 0, '0, acc);
    chk("flush_no_accept", acc, 0);
    chk("flush_o_valid", o_valid, 0);
    cycle(1, 0, 4'h9, 1, 1, 16'h0000, 16'h0000, 1, 0, 1, mk(16'h0000, 0, 0, 1, 1, 0), acc);
    idle(3, 1);

    // async reset mid-stream
    cycle(1, 0, 4'h9, 0, 0, 16'hFFFF, 16'h0001, 1, 0, 0, '0, acc);
    cycle(1, 0, 4'h9, 0, 0, 16'hFFFF, 16'h0001, 1, 0, 0, '0, acc);
    i_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("rst_async_o_valid", o_valid, 0);
    chk("rst_async_result", o_result, 0);
    q.delete(); mcarry = 1'b0;
    @(posedge clk); #2 rst_n = 1;
    @(posedge clk); #1;
    cycle(1, 0, 4'h9, 1, 1, 16'h0000, 16'h0000, 1, 0, 1, mk(16'h0000, 0, 0, 1, 1, 0), acc);
    idle(3, 1);

    // randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? a : 16'($urandom);
      cycle($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
            a, b, $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0, 0, '0, acc);
    end

    guard = 0;
    while (q.size() > 0 && guard < 20) begin idle(1, 1); guard++; end
    chk("drain_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
